// File: rtl/cpm_topk_stream_if.sv
// Valid/ready stream bundle for cpm_topk_stream: input items in, ranked result entries out.
// The master modport is the producer/consumer side; the slave modport is the selector.
interface cpm_topk_stream_if #(
    parameter int DATA_DW = 8,
    parameter int INFO_DW = 8,
    parameter int SORT_AW = 5,
    parameter int CNT_DW  = 16
);
    logic               in_vld;
    logic               in_rdy;
    logic               in_lst;
    logic [DATA_DW-1:0] in_dat;
    logic [INFO_DW-1:0] in_inf;

    logic               out_vld;
    logic               out_rdy;
    logic               out_lst;
    logic [DATA_DW-1:0] out_dat;
    logic [INFO_DW-1:0] out_inf;
    logic [SORT_AW-1:0] out_rnk;
    logic [CNT_DW-1:0]  out_cnt;

    modport master (
        output in_vld, in_lst, in_dat, in_inf, out_rdy,
        input  in_rdy, out_vld, out_lst, out_dat, out_inf, out_rnk, out_cnt
    );

    modport slave (
        input  in_vld, in_lst, in_dat, in_inf, out_rdy,
        output in_rdy, out_vld, out_lst, out_dat, out_inf, out_rnk, out_cnt
    );
endinterface

// File: rtl/cpm_topk_stream.sv
// Streaming top-K selector: keeps a sorted table of the K best (key, tag) pairs of a frame
// and streams it out rank by rank once the frame's last item has been inserted.
module cpm_topk_stream #(
    parameter int DATA_DW = 8,
    parameter int INFO_DW = 8,
    parameter int SORT_DW = 32,
    parameter int SORT_AW = $clog2(SORT_DW),
    parameter int SIGNED  = 0,
    parameter int CNT_DW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cfg_mode,
    input  logic [SORT_AW:0] cfg_k,
    output logic             busy,
    cpm_topk_stream_if.slave bus
);
    localparam int KW = SORT_AW + 1;
    // Flipping the sign bit turns a two's complement compare into an unsigned one.
    localparam logic [DATA_DW-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(DATA_DW-1){1'b0}}} : '0;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t             state;
    logic [DATA_DW-1:0] tbl_dat [SORT_DW];
    logic [INFO_DW-1:0] tbl_inf [SORT_DW];
    logic [SORT_DW-1:0] tbl_vld;
    logic [DATA_DW-1:0] nxt_dat [SORT_DW];
    logic [INFO_DW-1:0] nxt_inf [SORT_DW];
    logic [SORT_DW-1:0] nxt_vld;
    logic [SORT_DW-1:0] worse;
    logic [KW-1:0]      occ, k_q, k_clamp, k_eff;
    logic               mode_q, mode_eff, first, accept, out_hs, drain, load;
    logic [CNT_DW-1:0]  count;
    logic [SORT_AW-1:0] rnk;

    function automatic logic better(input logic [DATA_DW-1:0] a, input logic [DATA_DW-1:0] b,
                                    input logic mode);
        logic [DATA_DW-1:0] ax, bx;
        ax = a ^ FLIP;
        bx = b ^ FLIP;
        return mode ? (ax < bx) : (ax > bx);
    endfunction

    assign drain  = (state == DRAIN);
    assign accept = bus.in_vld && bus.in_rdy;
    assign out_hs = bus.out_vld && bus.out_rdy;
    assign first  = (occ == '0) && (count == '0);
    assign load   = accept && !rst_n && !clear;

    always_comb begin
        k_clamp = cfg_k;
        if (cfg_k == '0)
            k_clamp = KW'(1);
        else if (cfg_k > KW'(SORT_DW))
            k_clamp = KW'(SORT_DW);
    end

    assign k_eff    = first ? k_clamp  : k_q;
    assign mode_eff = first ? cfg_mode : mode_q;

    // Table is sorted with valid entries packed at the top, so worse[] is a thermometer code.
    always_comb begin
        worse = '0;
        for (int i = 0; i < SORT_DW; i++)
            worse[i] = !tbl_vld[i] || better(bus.in_dat, tbl_dat[i], mode_eff);
    end

    always_comb begin
        nxt_dat = tbl_dat;
        nxt_inf = tbl_inf;
        nxt_vld = tbl_vld;
        if (worse[0]) begin
            nxt_dat[0] = bus.in_dat;
            nxt_inf[0] = bus.in_inf;
            nxt_vld[0] = 1'b1;
        end
        for (int i = 1; i < SORT_DW; i++) begin
            if (KW'(i) < k_eff && worse[i]) begin
                if (worse[i-1]) begin
                    nxt_dat[i] = tbl_dat[i-1];
                    nxt_inf[i] = tbl_inf[i-1];
                    nxt_vld[i] = tbl_vld[i-1];
                end else begin
                    nxt_dat[i] = bus.in_dat;
                    nxt_inf[i] = bus.in_inf;
                    nxt_vld[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: key/tag storage has no reset; tbl_vld alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (load) begin
            tbl_dat <= nxt_dat;
            tbl_inf <= nxt_inf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            state   <= COLLECT;
            tbl_vld <= '0;
            occ     <= '0;
            count   <= '0;
            rnk     <= '0;
            k_q     <= KW'(1);
            mode_q  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        tbl_vld <= nxt_vld;
                        if (first) begin
                            k_q    <= k_clamp;
                            mode_q <= cfg_mode;
                        end
                        occ <= (occ >= k_eff) ? k_eff : occ + KW'(1);
                        if (count != '1)
                            count <= count + CNT_DW'(1);
                        if (bus.in_lst) begin
                            state <= DRAIN;
                            rnk   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (bus.out_lst) begin
                            state   <= COLLECT;
                            tbl_vld <= '0;
                            occ     <= '0;
                            count   <= '0;
                            rnk     <= '0;
                        end else begin
                            rnk <= rnk + SORT_AW'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_rdy  = (state == COLLECT);
    assign bus.out_vld = drain;
    assign bus.out_rnk = drain ? rnk : '0;
    assign bus.out_dat = drain ? tbl_dat[rnk] : '0;
    assign bus.out_inf = drain ? tbl_inf[rnk] : '0;
    assign bus.out_lst = drain && ({1'b0, rnk} == occ - KW'(1));
    assign bus.out_cnt = drain ? count : '0;
    assign busy        = drain || (count != '0);
endmodule

// File: tb/tb_cpm_topk_stream.sv
// Scoreboard bench for cpm_topk_stream: a selection-sort model queues the expected ranked
// entries of each frame, which are popped and compared as the DUT streams them out.
module tb_cpm_topk_stream;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int SD = 32;
    localparam int SA = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          cfg_mode;
    logic [SA:0]   cfg_k;
    logic          busy;

    always #5 clk = ~clk;

    cpm_topk_stream_if #(.DATA_DW(DW), .INFO_DW(IW), .SORT_AW(SA), .CNT_DW(CW)) bus ();

    cpm_topk_stream #(
        .DATA_DW(DW), .INFO_DW(IW), .SORT_DW(SD), .SORT_AW(SA), .SIGNED(1), .CNT_DW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_mode(cfg_mode), .cfg_k(cfg_k),
        .busy(busy), .bus(bus)
    );

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] dat;
        logic [IW-1:0] inf;
        logic [SA-1:0] rnk;
        logic          lst;
        logic [CW-1:0] cnt;
    } beat_t;

    beat_t         sb[$];
    logic [DW-1:0] frm_dat[$];
    logic [IW-1:0] frm_inf[$];
    int            checks = 0;
    int            failures = 0;

    function automatic beat_t observe();
        beat_t b;
        b.vld = bus.out_vld;
        b.dat = bus.out_dat;
        b.inf = bus.out_inf;
        b.rnk = bus.out_rnk;
        b.lst = bus.out_lst;
        b.cnt = bus.out_cnt;
        return b;
    endfunction

    function automatic bit tb_better(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit mode);
        int ai = $signed(a);
        int bi = $signed(b);
        return mode ? (ai < bi) : (ai > bi);
    endfunction

    task automatic add(input int dat, input int inf);
        frm_dat.push_back(DW'(dat));
        frm_inf.push_back(IW'(inf));
    endtask

    task automatic model(input int k, input bit mode);
        int    n  = frm_dat.size();
        int    kk = (k < 1) ? 1 : ((k > SD) ? SD : k);
        int    m  = (n < kk) ? n : kk;
        int    c  = (n > 15) ? 15 : n;
        bit    used [64];
        int    best;
        beat_t b;
        for (int j = 0; j < 64; j++) used[j] = 1'b0;
        for (int r = 0; r < m; r++) begin
            best = -1;
            for (int j = 0; j < n; j++)
                if (!used[j] && (best < 0 || tb_better(frm_dat[j], frm_dat[best], mode)))
                    best = j;
            used[best] = 1'b1;
            b.vld = 1'b1;
            b.dat = frm_dat[best];
            b.inf = frm_inf[best];
            b.rnk = SA'(r);
            b.lst = (r == m - 1);
            b.cnt = CW'(c);
            sb.push_back(b);
        end
    endtask

    task automatic compare_beat(input string name, input beat_t exp);
        beat_t o = observe();
        checks++;
        if (o !== exp) begin
            failures++;
            $display("FAIL %s: got vld=%0b dat=%0d inf=%0d rnk=%0d lst=%0b cnt=%0d, want vld=%0b dat=%0d inf=%0d rnk=%0d lst=%0b cnt=%0d",
                     name, o.vld, o.dat, o.inf, o.rnk, o.lst, o.cnt,
                     exp.vld, exp.dat, exp.inf, exp.rnk, exp.lst, exp.cnt);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({bus.in_rdy, bus.out_vld, busy} !== 3'b100) begin
            failures++;
            $display("FAIL %s idle: got in_rdy/out_vld/busy=%b want 100", name,
                     {bus.in_rdy, bus.out_vld, busy});
        end
    endtask

    // Drives the queued frame; cfg is optionally changed after the first item.
    task automatic send_frame(input string name, input int k, input bit mode, input bit chg);
        int n = frm_dat.size();
        int g;
        cfg_k    = (SA+1)'(k);
        cfg_mode = mode;
        model(k, mode);
        for (int i = 0; i < n; i++) begin
            bus.in_vld = 1'b1;
            bus.in_dat = frm_dat[i];
            bus.in_inf = frm_inf[i];
            bus.in_lst = (i == n - 1);
            g = 0;
            while (bus.in_rdy !== 1'b1 && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 50) begin
                checks++;
                failures++;
                $display("FAIL %s in_rdy timeout: got 0 want 1", name);
            end
            @(posedge clk); #1;
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy after first item: got %b want 1", name, busy);
                end
                if (chg) begin
                    cfg_mode = ~mode;
                    cfg_k    = 6'd4;
                end
            end
        end
        bus.in_vld = 1'b0;
        bus.in_lst = 1'b0;
        frm_dat.delete();
        frm_inf.delete();
    endtask

    task automatic drain(input string name, input bit rand_rdy);
        int guard = 0;
        while (sb.size() > 0 && guard < 500) begin
            compare_beat(name, sb[0]);
            bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (bus.out_rdy) void'(sb.pop_front());
            guard++;
        end
        bus.out_rdy = 1'b0;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s drain timeout: %0d entries left, want 0", name, sb.size());
            sb.delete();
        end
        check_idle(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; clear = 1'b0; cfg_mode = 1'b0; cfg_k = '0;
        bus.in_vld = 1'b0; bus.in_lst = 1'b0; bus.in_dat = '0; bus.in_inf = '0; bus.out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        compare_beat("reset outputs", '0);
        check_idle("reset");
    endtask

    task automatic test_largest();
        add(5, 0); add(9, 1); add(1, 2); add(9, 3); add(7, 4);
        send_frame("largest", 4, 1'b0, 1'b0);
        drain("largest", 1'b0);
    endtask

    task automatic test_signed_smallest();
        add(-2, 10); add(0, 11); add(-8, 12); add(3, 13); add(-2, 14);
        send_frame("signed_smallest", 3, 1'b1, 1'b0);
        drain("signed_smallest", 1'b0);
    endtask

    task automatic test_zeros();
        add(0, 1); add(0, 2); add(0, 3);
        send_frame("zeros", 2, 1'b0, 1'b0);
        drain("zeros", 1'b0);
    endtask

    task automatic test_single_hold();
        add(42, 7);
        send_frame("single", 4, 1'b0, 1'b0);
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            compare_beat("single hold", sb[0]);
            @(posedge clk); #1;
        end
        drain("single", 1'b0);
    endtask

    task automatic test_clear();
        add(10, 1); add(20, 2); add(30, 3); add(40, 4);
        send_frame("clear", 4, 1'b0, 1'b0);
        compare_beat("clear rank0", sb[0]);
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        void'(sb.pop_front());
        compare_beat("clear rank1", sb[0]);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.out_rdy = 1'b0;
        sb.delete();
        check_idle("after clear");
        add(3, 1); add(8, 2);
        send_frame("post_clear", 2, 1'b1, 1'b0);
        drain("post_clear", 1'b0);
    endtask

    task automatic test_k_bounds();
        add(4, 0); add(11, 1); add(6, 2);
        send_frame("k_zero", 0, 1'b0, 1'b1);
        drain("k_zero", 1'b0);
        for (int i = 0; i < 35; i++) add(int'($urandom_range(0, 255)), i);
        send_frame("k_40", 40, 1'b0, 1'b0);
        drain("k_40", 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 6; i++) add(int'($urandom_range(0, 255)), 16 * f + i);
            send_frame("back_to_back", 3, f[0], 1'b0);
            drain("back_to_back", f == 1);
        end
    endtask

    initial begin
        test_reset();
        test_largest();
        test_signed_smallest();
        test_zeros();
        test_single_hold();
        test_clear();
        test_k_bounds();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
